gpio_req_sched: RTL and testbench
=================================

Name: gpio_req_sched

Overview:
- Round-robin scheduler that shares the DUT-facing GPIO pin bank between NUM_REQ agent-side requesters.
- Owns the registered gpio_out vector and applies masked WRITE/TOGGLE commands from one requester at a time.
- Also executes blocking WAIT commands that poll the synchronised gpio_in vector against a masked pattern, with a timeout.
- Sits between sequence-level drivers and the pin-level GPIO interface; one command is in flight at any time.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- GPIO_W, 1024: pin vector width.
- TO_W, 16: timeout counter width.
- SYNC_STAGES, 2: gpio_in synchroniser depth, 1..4.
- RESET_VAL, '0: gpio_out value after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  one-hot accept, asserted only to the granted requester.
- req_op  in  NUM_REQ x 2  op per requester (gpio_sched_pkg::op_e).
- req_mask  in  NUM_REQ x GPIO_W  bit mask.
- req_data  in  NUM_REQ x GPIO_W  write value or wait pattern.
- req_timeout  in  NUM_REQ x TO_W  wait limit in cycles; 0 = no limit.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the completed command.
- rsp_status  out  2  OK=0, TIMEOUT=1 (gpio_sched_pkg::status_e).
- gpio_in  in  GPIO_W  DUT outputs (asynchronous).
- gpio_out  out  GPIO_W  DUT inputs (registered).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: gpio_out=RESET_VAL; req_ready=0; rsp_valid=0; rsp_id=0; rsp_status=OK; busy=0; RR pointer=NUM_REQ-1 (requester 0 has first priority); synchroniser flops=0.
- Reset mid-command aborts the command with no response; gpio_out returns to RESET_VAL.
- Ops:
  - WRITE=0: gpio_out <= (gpio_out & ~mask) | (data & mask).
  - TOGGLE=1: gpio_out <= gpio_out ^ mask.
  - WAIT_EQ=2: complete when (sync_in & mask) == (data & mask).
  - WAIT_NE=3: complete when (sync_in & mask) != (data & mask).
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set index after the RR pointer, wrapping modulo NUM_REQ.
  - req_ready[g] is driven combinationally in the same cycle; acceptance is valid&&ready.
  - Latch op/mask/data/timeout/id; the RR pointer becomes g.
  - WRITE/TOGGLE go to EXEC; WAITs go to WAIT.
  - Requesters must not make req_valid depend on req_ready.
- EXEC: update gpio_out at the end of this cycle; go to RESP.
- WAIT:
  - Evaluate the condition every cycle on sync_in, the last synchroniser stage. Counter cnt starts at 0.
  - Condition true: go to RESP with OK, checked before timeout.
  - Otherwise, if timeout!=0 and cnt==timeout-1: go to RESP with TIMEOUT. Otherwise cnt++.
  - A condition already true on the first WAIT cycle completes with OK.
  - timeout=1 gives exactly one evaluation.
- RESP: rsp_valid=1 for one cycle with the latched id and status; go to IDLE. There is no response backpressure.
- Latency, acceptance at cycle T:
  - WRITE/TOGGLE: gpio_out changes at edge T+2; rsp_valid in cycle T+2.
  - WAIT that is true at once: rsp_valid in cycle T+2.
  - WAIT timeout N: rsp_valid in cycle T+N+1.
  - Back-to-back: the next grant is possible in cycle T+3 at the earliest.
- Unselected requesters holding req_valid stay pending; they are never dropped.
- Starvation bound: any requester is served within NUM_REQ-1 intervening commands.
- No arithmetic overflow: cnt saturates is unnecessary because it stops at timeout-1. For timeout=0 the counter is frozen.
- gpio_out changes only in EXEC, never during WAIT.

Decomposition:
- gpio_sched_pkg holds:
  - op_e (WRITE, TOGGLE, WAIT_EQ, WAIT_NE).
  - status_e (OK, TIMEOUT).
  - state_e (IDLE, EXEC, WAIT, RESP).
  - Default width localparams.
- Sub-module gpio_rr_arbiter (NUM_REQ): request vector, pointer, update strobe -> one-hot grant and index.
- The synchroniser is an inline generate loop.

Test Plan:
- Reset: assert rst mid-WAIT with RESET_VAL=32'hA5 (GPIO_W=32) -> gpio_out=32'hA5 asynchronously, no rsp_valid, busy=0.
- Masked write: gpio_out=0, req0 WRITE mask=32'h0000FF00 data=32'h12345678 -> gpio_out=32'h00005600 at T+2, rsp_id=0 OK.
- Toggle:
  - TOGGLE mask=32'hF from 32'h00005600 -> 32'h0000560F.
  - Repeat -> 32'h00005600.
- Round-robin: req0..req3 all valid continuously -> grants 0,1,2,3,0 in that order; each grant is 3 cycles apart for WRITEs.
- Wait OK: WAIT_EQ mask=32'h1 data=1 timeout=20; drive gpio_in[0]=1 at cycle T+5 -> with 2 sync stages, rsp_valid in cycle T+7 or T+8 with OK, never later than T+8.
- Wait timeout: WAIT_NE mask=32'hF data=gpio_in timeout=5, gpio_in held constant -> rsp_status=TIMEOUT in cycle T+6. With timeout=0 and a constant input, no response within 1000 cycles and busy stays 1.

Source files
------------

// File: rtl/gpio_sched_pkg.sv
// Shared types and default sizes for the GPIO request scheduler.
package gpio_sched_pkg;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'd0,
    OP_TOGGLE  = 2'd1,
    OP_WAIT_EQ = 2'd2,
    OP_WAIT_NE = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK      = 2'd0,
    STAT_TIMEOUT = 2'd1
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_GPIO_W      = 1024;
  localparam int unsigned DEF_TO_W        = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/gpio_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module gpio_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic                       i_update,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0] r_ptr;

  always_comb begin
    int unsigned w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_pos = (32'(r_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
      end
    end
  end

  // Pointer starts at the last index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ptr <= IW'(NUM_REQ - 1);
    else if (i_update) r_ptr <= o_idx;
  end

endmodule

// File: rtl/gpio_req_sched.sv
// Shares the GPIO pin bank between requesters: masked write/toggle of gpio_out
// and timed waits on the synchronised gpio_in, one command at a time.
module gpio_req_sched
  import gpio_sched_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned       GPIO_W      = DEF_GPIO_W,
  parameter int unsigned       TO_W        = DEF_TO_W,
  parameter int unsigned       SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [GPIO_W-1:0] RESET_VAL   = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][1:0]           req_op,
  input  logic [NUM_REQ-1:0][GPIO_W-1:0]    req_mask,
  input  logic [NUM_REQ-1:0][GPIO_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0][TO_W-1:0]      req_timeout,
  output logic                              rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [1:0]                        rsp_status,
  input  logic [GPIO_W-1:0]                 gpio_in,
  output logic [GPIO_W-1:0]                 gpio_out,
  output logic                              busy
);
  localparam int unsigned IW = $clog2(NUM_REQ);

  state_e              r_state;
  op_e                 r_op;
  status_e             r_status;
  logic [GPIO_W-1:0]   r_mask, r_data, r_gpio;
  logic [TO_W-1:0]     r_timeout, r_cnt;
  logic [IW-1:0]       r_id;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_idx;
  logic                w_any, w_accept, w_match, w_cond;
  logic [GPIO_W-1:0]   w_sync_in;
  op_e                 w_op;

  for (genvar gs = 0; gs < SYNC_STAGES; gs++) begin : g_sync
    logic [GPIO_W-1:0] r_q;
    if (gs == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= gpio_in;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= g_sync[gs-1].r_q;
      end
    end
  end
  assign w_sync_in = g_sync[SYNC_STAGES-1].r_q;

  assign w_accept = (r_state == S_IDLE) && w_any;

  gpio_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid),
    .i_update (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_comb begin
    w_op    = op_e'(req_op[w_idx]);
    w_match = (w_sync_in & r_mask) == (r_data & r_mask);
    w_cond  = (r_op == OP_WAIT_NE) ? !w_match : w_match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= OP_WRITE;
      r_status  <= STAT_OK;
      r_mask    <= '0;
      r_data    <= '0;
      r_timeout <= '0;
      r_cnt     <= '0;
      r_id      <= '0;
      r_gpio    <= RESET_VAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op      <= w_op;
            r_mask    <= req_mask[w_idx];
            r_data    <= req_data[w_idx];
            r_timeout <= req_timeout[w_idx];
            r_id      <= w_idx;
            r_cnt     <= '0;
            r_state   <= (w_op == OP_WAIT_EQ || w_op == OP_WAIT_NE) ? S_WAIT : S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_WRITE:  r_gpio <= (r_gpio & ~r_mask) | (r_data & r_mask);
            OP_TOGGLE: r_gpio <= r_gpio ^ r_mask;
            default:   r_gpio <= r_gpio;
          endcase
          r_status <= STAT_OK;
          r_state  <= S_RESP;
        end
        S_WAIT: begin
          // Match wins over timeout; a zero limit leaves the counter frozen.
          if (w_cond) begin
            r_status <= STAT_OK;
            r_state  <= S_RESP;
          end else if (r_timeout != '0 && r_cnt == r_timeout - TO_W'(1)) begin
            r_status <= STAT_TIMEOUT;
            r_state  <= S_RESP;
          end else if (r_timeout != '0) begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_accept ? w_grant : '0;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_status = r_status;
  assign gpio_out   = r_gpio;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpio_req_sched.sv
// Randomised self-checking bench for gpio_req_sched against a behavioural model.
module tb_gpio_req_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 16;
  localparam logic [W-1:0] RV = 32'hA5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid, req_ready;
  logic [N-1:0][1:0]     req_op;
  logic [N-1:0][W-1:0]   req_mask, req_data;
  logic [N-1:0][TW-1:0]  req_timeout;
  logic                  rsp_valid, busy;
  logic [1:0]            rsp_id, rsp_status;
  logic [W-1:0]          gpio_in, gpio_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_g = N - 1;
  logic [W-1:0] m_gpio;

  gpio_req_sched #(
    .NUM_REQ     (N),
    .GPIO_W      (W),
    .TO_W        (TW),
    .SYNC_STAGES (2),
    .RESET_VAL   (RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_mask    (req_mask),
    .req_data    (req_data),
    .req_timeout (req_timeout),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_status  (rsp_status),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_grant(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] apply(input logic [W-1:0] g, input logic [1:0] op,
                                         input logic [W-1:0] m, input logic [W-1:0] d);
    if (op == 2'd0) return (g & ~m) | (d & m);
    if (op == 2'd1) return g ^ m;
    return g;
  endfunction

  function automatic bit wait_done(input logic [1:0] op, input logic [W-1:0] gin,
                                   input logic [W-1:0] m, input logic [W-1:0] d);
    bit eq;
    eq = ((gin & m) == (d & m));
    return (op == 2'd2) ? eq : !eq;
  endfunction

  task automatic issue(input int r, input logic [1:0] op, input logic [W-1:0] m,
                       input logic [W-1:0] d, input logic [TW-1:0] to, output int t_acc);
    int n = 0;
    logic [N-1:0] exp_rdy;
    req_op[r] = op; req_mask[r] = m; req_data[r] = d; req_timeout[r] = to;
    req_valid[r] = 1'b1;
    #1;
    while (!req_ready[r] && n < 30) begin tick(); n++; end
    checks++;
    if (!req_ready[r]) begin
      errors++;
      $display("FAIL grant_wait r=%0d got ready=%b required bit %0d set", r, req_ready, r);
      t_acc = -1;
    end else begin
      exp_rdy = '0;
      exp_rdy[r] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL ready_onehot got %b required %b", req_ready, exp_rdy);
      end
      t_acc  = cyc;
      last_g = r;
    end
    tick();
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int t_rsp);
    int n = 0;
    while (!rsp_valid && n < budget) begin tick(); n++; end
    t_rsp = rsp_valid ? cyc : -1;
  endtask

  task automatic do_cmd(input int r, input logic [1:0] op, input logic [W-1:0] m,
                        input logic [W-1:0] d);
    int t_acc, t_rsp;
    issue(r, op, m, d, '0, t_acc);
    if (t_acc < 0) return;
    checks++;
    if (gpio_out !== m_gpio || busy !== 1'b1) begin
      errors++;
      $display("FAIL exec_hold got gpio=%h busy=%b required gpio=%h busy=1", gpio_out, busy, m_gpio);
    end
    m_gpio = apply(m_gpio, op, m, d);
    wait_rsp(10, t_rsp);
    checks++;
    if (t_rsp != t_acc + 2) begin
      errors++;
      $display("FAIL cmd_latency got cycle %0d required %0d", t_rsp, t_acc + 2);
    end
    checks++;
    if (gpio_out !== m_gpio || rsp_id !== 2'(r) || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL cmd_result got gpio=%h id=%0d st=%0d required gpio=%h id=%0d st=0",
               gpio_out, rsp_id, rsp_status, m_gpio, r);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_op = '0; req_mask = '0; req_data = '0;
    req_timeout = '0; gpio_in = '0;
    tick(); tick();
    checks++;
    if (gpio_out !== RV || req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_id !== 2'd0 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got gpio=%h rdy=%b rv=%b busy=%b id=%0d st=%0d required gpio=%h rest 0",
               gpio_out, req_ready, rsp_valid, busy, rsp_id, rsp_status, RV);
    end
    rst = 1'b0;
    m_gpio = RV;
    last_g = N - 1;
    tick();
  endtask

  task automatic test_write();
    do_cmd(0, 2'd0, 32'hFFFF_FFFF, 32'h0);
    do_cmd(0, 2'd0, 32'h0000_FF00, 32'h1234_5678);
    checks++;
    if (gpio_out !== 32'h0000_5600) begin
      errors++;
      $display("FAIL masked_write got %h required %h", gpio_out, 32'h0000_5600);
    end
  endtask

  task automatic test_toggle();
    do_cmd(0, 2'd1, 32'hF, 32'h0);
    checks++;
    if (gpio_out !== 32'h0000_560F) begin
      errors++;
      $display("FAIL toggle_1 got %h required %h", gpio_out, 32'h0000_560F);
    end
    do_cmd(3, 2'd1, 32'hF, $urandom);
    checks++;
    if (gpio_out !== 32'h0000_5600) begin
      errors++;
      $display("FAIL toggle_2 got %h required %h", gpio_out, 32'h0000_5600);
    end
  endtask

  task automatic test_back_to_back();
    int grants = 0, n = 0, exp_g, last_t = 0, due = 0, pid = 0, refresh = -1;
    bit pend = 0, stop = 0;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_op[i] = 2'($urandom_range(0, 1)); req_mask[i] = $urandom; req_data[i] = $urandom;
    end
    req_valid = '1;
    exp_g = next_grant(req_valid, last_g);
    #1;
    while ((grants < 5 || pend) && n < 80) begin
      if (stop) req_valid = '0;
      if (refresh >= 0) begin
        req_op[refresh] = 2'($urandom_range(0, 1));
        req_mask[refresh] = $urandom; req_data[refresh] = $urandom;
        refresh = -1;
      end
      if (pend && cyc == due) begin
        pend = 0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(pid) || gpio_out !== m_gpio) begin
          errors++;
          $display("FAIL rr_rsp got rv=%b id=%0d gpio=%h required rv=1 id=%0d gpio=%h",
                   rsp_valid, rsp_id, gpio_out, pid, m_gpio);
        end
      end
      if (req_ready !== '0 && grants < 5 && !stop) begin
        exp_rdy = '0;
        exp_rdy[exp_g] = 1'b1;
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL rr_order got %b required %b", req_ready, exp_rdy);
        end
        if (grants > 0) begin
          checks++;
          if (cyc - last_t != 3) begin
            errors++;
            $display("FAIL rr_spacing got %0d cycles required 3", cyc - last_t);
          end
        end
        m_gpio = apply(m_gpio, req_op[exp_g], req_mask[exp_g], req_data[exp_g]);
        pend = 1; due = cyc + 2; pid = exp_g; last_t = cyc;
        last_g = exp_g; refresh = exp_g;
        grants++;
        if (grants == 5) stop = 1;
        exp_g = next_grant('1, last_g);
      end
      tick();
      n++;
    end
    req_valid = '0;
    checks++;
    if (grants != 5 || pend) begin
      errors++;
      $display("FAIL rr_complete got %0d grants pend=%0d required 5 grants pend=0", grants, pend);
    end
    tick();
  endtask

  task automatic test_wait_ok();
    int t_acc, t_rsp;
    gpio_in = '0;
    tick(); tick(); tick();
    issue(1, 2'd2, 32'h1, 32'h1, 16'd20, t_acc);
    if (t_acc < 0) return;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_busy got busy=%b rv=%b required busy=1 rv=0", busy, rsp_valid);
    end
    while (cyc < t_acc + 5) tick();
    gpio_in = 32'h1;
    wait_rsp(12, t_rsp);
    checks++;
    if (t_rsp < t_acc + 7 || t_rsp > t_acc + 8) begin
      errors++;
      $display("FAIL wait_ok_latency got cycle %0d required %0d..%0d", t_rsp, t_acc + 7, t_acc + 8);
    end
    checks++;
    if (rsp_status !== 2'd0 || rsp_id !== 2'd1 || gpio_out !== m_gpio) begin
      errors++;
      $display("FAIL wait_ok_rsp got st=%0d id=%0d gpio=%h required st=0 id=1 gpio=%h",
               rsp_status, rsp_id, gpio_out, m_gpio);
    end
    tick();
  endtask

  task automatic test_wait_timeout();
    int t_acc, t_rsp;
    gpio_in = 32'h5;
    tick(); tick(); tick();
    issue(2, 2'd3, 32'hF, gpio_in, 16'd5, t_acc);
    if (t_acc < 0) return;
    wait_rsp(20, t_rsp);
    checks++;
    if (t_rsp != t_acc + 6 || rsp_status !== 2'd1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL wait_timeout got cycle %0d st=%0d id=%0d required cycle %0d st=1 id=2",
               t_rsp, rsp_status, rsp_id, t_acc + 6);
    end
    tick();
  endtask

  task automatic test_wait_random();
    int t_acc, t_rsp, r, exp_t;
    logic [1:0] op;
    logic [W-1:0] gin, m, d;
    logic [TW-1:0] to;
    bit done;
    for (int it = 0; it < 10; it++) begin
      gin = $urandom;
      gpio_in = gin;
      tick(); tick(); tick();
      r  = $urandom_range(0, N - 1);
      op = 2'($urandom_range(2, 3));
      m  = $urandom;
      d  = $urandom_range(0, 1) ? gin : $urandom;
      to = TW'($urandom_range(1, 8));
      done  = wait_done(op, gin, m, d);
      issue(r, op, m, d, to, t_acc);
      if (t_acc < 0) continue;
      exp_t = done ? t_acc + 2 : t_acc + int'(to) + 1;
      wait_rsp(20, t_rsp);
      checks++;
      if (t_rsp != exp_t || rsp_status !== (done ? 2'd0 : 2'd1) || rsp_id !== 2'(r) ||
          gpio_out !== m_gpio) begin
        errors++;
        $display("FAIL wait_rand it=%0d got cycle %0d st=%0d id=%0d gpio=%h required cycle %0d st=%0d id=%0d gpio=%h",
                 it, t_rsp, rsp_status, rsp_id, gpio_out, exp_t, done ? 0 : 1, r, m_gpio);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    int t_acc;
    bit saw_rsp = 0, dropped_busy = 0;
    gpio_in = 32'h3C;
    tick(); tick(); tick();
    issue(0, 2'd3, 32'hF, gpio_in, 16'd0, t_acc);
    if (t_acc < 0) return;
    for (int i = 0; i < 1000; i++) begin
      if (rsp_valid) saw_rsp = 1;
      if (busy !== 1'b1) dropped_busy = 1;
      tick();
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("FAIL wait_no_limit got rsp_valid within 1000 cycles required none");
    end
    checks++;
    if (dropped_busy) begin
      errors++;
      $display("FAIL wait_busy_held got busy low required busy=1 throughout");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gpio_out !== RV || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL async_reset got gpio=%h busy=%b rv=%b required gpio=%h busy=0 rv=0",
               gpio_out, busy, rsp_valid, RV);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) saw_rsp = 1;
      tick();
    end
    checks++;
    if (saw_rsp || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got rv_seen=%0d busy=%b required rv_seen=0 busy=0", saw_rsp, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_toggle();
    test_back_to_back();
    test_wait_ok();
    test_wait_timeout();
    test_wait_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
